// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared constants, types and helpers for the Vedic multiplier pipeline
package vedic_pkg;

  localparam int VEDIC_LATENCY = 3;

  // Bit i is the valid flag of stage Si.
  typedef logic [VEDIC_LATENCY-1:0] stage_valid_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/vedic_mult_pipe_if.sv
// rtl/vedic_mult_pipe_if.sv - operand/product handshake bundle for vedic_mult_pipe
interface vedic_mult_pipe_if
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          a;
  logic [WIDTH-1:0]          b;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [prod_w(WIDTH)-1:0]  c;
  logic [TAG_W-1:0]          out_tag;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, c, out_tag
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, c, out_tag
  );
endinterface

// File: rtl/vedic_mult_core.sv
// rtl/vedic_mult_core.sv - combinational Urdhva-Tiryagbhyam multiplier, recursive down to a 2x2 gate leaf
module vedic_mult_core #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  generate
    if (W == 2) begin : g_leaf
      logic t_lh, t_hl, t_hh, c1;
      assign t_lh = a[1] & b[0];
      assign t_hl = a[0] & b[1];
      assign t_hh = a[1] & b[1];
      assign c1   = t_lh & t_hl;
      assign p    = {t_hh & c1, t_hh ^ c1, t_lh ^ t_hl, a[0] & b[0]};
    end else begin : g_node
      localparam int H = W / 2;
      logic [W-1:0] hh, hl, lh, ll;
      logic [W:0]   mid;

      vedic_mult_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
      vedic_mult_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
      vedic_mult_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
      vedic_mult_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));

      // Cross terms can carry into bit W, so the middle sum keeps W+1 bits.
      assign mid = {1'b0, hl} + {1'b0, lh};
      assign p   = {hh, ll} + ({{(W-1){1'b0}}, mid} << H);
    end
  endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - 3-stage valid/ready Vedic multiplier; VEDIC_MULT_SIGNED_EN selects two's-complement operands
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  vedic_mult_pipe_if.slave bus
);

  localparam int HW = WIDTH / 2;
  localparam int PW = prod_w(WIDTH);

  stage_valid_t       vld;
  logic               adv;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [TAG_W-1:0]   tag0, tag1, tag_out;

  logic [WIDTH-1:0]   hh, hl, lh, ll;
  logic [WIDTH-1:0]   pp_hh, pp_hl, pp_lh, pp_ll;
  logic [WIDTH:0]     mid;
  logic [PW-1:0]      sum, res, c_q;

  // Stages move in lockstep; a stalled output freezes the whole pipe.
  assign adv           = !vld[VEDIC_LATENCY-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[VEDIC_LATENCY-1];
  assign bus.c         = c_q;
  assign bus.out_tag   = tag_out;

`ifdef VEDIC_MULT_SIGNED_EN
  logic sign_in, sign0, sign1;
  // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
  assign a_mag   = bus.a[WIDTH-1] ? (~bus.a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a;
  assign b_mag   = bus.b[WIDTH-1] ? (~bus.b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.b;
  assign sign_in = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign0 <= 1'b0;
      sign1 <= 1'b0;
    end else if (adv) begin
      sign0 <= sign_in;
      sign1 <= sign0;
    end
  end
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  vedic_mult_core #(.W(HW)) u_hh (.a(a_q[WIDTH-1:HW]), .b(b_q[WIDTH-1:HW]), .p(hh));
  vedic_mult_core #(.W(HW)) u_hl (.a(a_q[WIDTH-1:HW]), .b(b_q[HW-1:0]),    .p(hl));
  vedic_mult_core #(.W(HW)) u_lh (.a(a_q[HW-1:0]),    .b(b_q[WIDTH-1:HW]), .p(lh));
  vedic_mult_core #(.W(HW)) u_ll (.a(a_q[HW-1:0]),    .b(b_q[HW-1:0]),    .p(ll));

  assign mid = {1'b0, pp_hl} + {1'b0, pp_lh};
  assign sum = {pp_hh, pp_ll} + ({{(WIDTH-1){1'b0}}, mid} << HW);

`ifdef VEDIC_MULT_SIGNED_EN
  assign res = sign1 ? (~sum + {{(PW-1){1'b0}}, 1'b1}) : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag0    <= '0;
      pp_hh   <= '0;
      pp_hl   <= '0;
      pp_lh   <= '0;
      pp_ll   <= '0;
      tag1    <= '0;
      c_q     <= '0;
      tag_out <= '0;
    end else if (adv) begin
      vld     <= {vld[VEDIC_LATENCY-2:0], bus.in_valid};
      a_q     <= a_mag;
      b_q     <= b_mag;
      tag0    <= bus.in_tag;
      pp_hh   <= hh;
      pp_hl   <= hl;
      pp_lh   <= lh;
      pp_ll   <= ll;
      tag1    <= tag0;
      c_q     <= res;
      tag_out <= tag1;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb/tb_vedic_mult_pipe.sv - scoreboard bench for vedic_mult_pipe (8-bit streaming, 16-bit directed)
module tb_vedic_mult_pipe;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rnd_on = 0;

  vedic_mult_pipe_if #(.WIDTH(8),  .TAG_W(8)) bus ();
  vedic_mult_pipe_if #(.WIDTH(16), .TAG_W(1)) bus16 ();

  vedic_mult_pipe #(.WIDTH(8),  .TAG_W(8)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  vedic_mult_pipe #(.WIDTH(16), .TAG_W(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    logic [15:0] c;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
`ifdef VEDIC_MULT_SIGNED_EN
    sx = $signed(x);
    sy = $signed(y);
`else
    sx = x;
    sy = y;
`endif
    return 16'(sx * sy);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] t, input logic [15:0] e);
    int  w = 0;
    bit  done = 0;
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.b        = y;
    bus.in_tag   = t;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{c: e, tag: t});
        done = 1;
      end
      step();
      w++;
      if (!done && w > 1000) begin
        timeout("send");
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      step();
      w++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  // Monitor: handshake rule, stall stability and in-order product/tag checks.
  initial begin
    bit          prev_stall = 0;
    logic [15:0] prev_c;
    logic [7:0]  prev_tag;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        chk("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
        if (prev_stall) begin
          chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("stall_c",     {16'd0, bus.c},         {16'd0, prev_c});
          chk("stall_tag",   {24'd0, bus.out_tag},   {24'd0, prev_tag});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {16'd0, bus.c}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("product", {16'd0, bus.c},       {16'd0, e.c});
            chk("tag",     {24'd0, bus.out_tag}, {24'd0, e.tag});
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_c     = bus.c;
        prev_tag   = bus.out_tag;
      end
    end
  end

  logic [15:0] d8_a[7]   = '{16'h0000, 16'h0A14, 16'h110B, 16'hFFFF, 16'hFFFF, 16'h807F, 16'h8080};
`ifdef VEDIC_MULT_SIGNED_EN
  logic [15:0] d8_e[7]   = '{16'h0000, 16'h00C8, 16'h00BB, 16'h0001, 16'h0001, 16'hC080, 16'h4000};
  logic [31:0] d16_e[3]  = '{32'h0000_0001, 32'h0626_0060, 32'h4000_0000};
`else
  logic [15:0] d8_e[7]   = '{16'h0000, 16'h00C8, 16'h00BB, 16'hFE01, 16'hFE01, 16'h3F80, 16'h4000};
  logic [31:0] d16_e[3]  = '{32'hFFFE_0001, 32'h0626_0060, 32'h4000_0000};
`endif
  logic [31:0] d16_ab[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_8000};

  initial begin
    int w;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.in_tag    = '0;
    bus16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_c",         {16'd0, bus.c},         32'd0);
    chk("reset_tag",       {24'd0, bus.out_tag},   32'd0);
    rst_n = 1'b1;
    step();
    chk("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);

    // Back-to-back directed vectors, latency of three edges.
    for (int i = 0; i < 4; i++) begin
      send(d8_a[i][15:8], d8_a[i][7:0], 8'(i), d8_e[i]);
      if (i < 2) chk("latency_early", {31'd0, bus.out_valid}, 32'd0);
      else       chk("latency_first", {31'd0, bus.out_valid}, 32'd1);
    end
    for (int i = 4; i < 7; i++) send(d8_a[i][15:8], d8_a[i][7:0], 8'(i), d8_e[i]);
    drain();

    // Backpressure for 5 cycles once the first result shows.
    fork
      begin
        send(8'd0, 8'd0, 8'd20, 16'h0000);
        send(8'd1, 8'd2, 8'd21, 16'h0002);
        send(8'd3, 8'd4, 8'd22, 16'h000C);
        send(8'd5, 8'd6, 8'd23, 16'h001E);
      end
      begin
        w = 0;
        while (!bus.out_valid && w < 50) begin
          step();
          w++;
        end
        if (!bus.out_valid) timeout("stall_wait");
        bus.out_ready = 1'b0;
        repeat (5) begin
          step();
          chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
          chk("stall_c_zero",   {16'd0, bus.c},        32'd0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with operations in flight.
    send(8'd7, 8'd8, 8'd30, ref8(8'd7, 8'd8));
    send(8'd9, 8'd9, 8'd31, ref8(8'd9, 8'd9));
    send(8'd6, 8'd6, 8'd32, ref8(8'd6, 8'd6));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_c",         {16'd0, bus.c},         32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (6) step();
    send(8'd3, 8'd5, 8'd9, 16'h000F);
    drain();

    // 16-bit instance: middle-sum carry and extreme operands.
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a        = d16_ab[i][31:16];
      bus16.b        = d16_ab[i][15:0];
      bus16.in_tag   = 1'(i);
      step();
      bus16.in_valid = 1'b0;
      step();
      chk("w16_early", {31'd0, bus16.out_valid}, 32'd0);
      step();
      chk("w16_valid", {31'd0, bus16.out_valid}, 32'd1);
      chk("w16_c",     bus16.c,                  d16_e[i]);
      chk("w16_tag",   {31'd0, bus16.out_tag},   {31'd0, 1'(i)});
    end

    // Random operands, bubbles and output backpressure.
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          bus.out_ready = ($urandom % 4) != 0;
          step();
        end
        bus.out_ready = 1'b1;
      end
      begin
        logic [7:0] x, y;
        for (int i = 0; i < 10000; i++) begin
          if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) step();
          x = 8'($urandom);
          y = 8'($urandom);
          send(x, y, 8'(i), ref8(x, y));
        end
        rnd_on = 0;
      end
    join
    drain();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
